// File: rtl/ofdm_rx_byte_packer.sv
// OFDM RX byte packer.
// Packs demodulated QPSK dibits into bytes aligned to each OFDM symbol start.
// Bytes go into a first-word-fall-through FIFO drained over a valid/ready stream.
// Malformed symbols and FIFO overflow drops are reported through saturating counters.
module ofdm_rx_byte_packer #(
   parameter int carriers_c   = 64,
   parameter int fifo_depth_c = 32,
   parameter int cnt_width_c  = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   sys_init,
   input  logic [1:0]             rx_rcv_data,
   input  logic                   rx_rcv_data_valid,
   input  logic                   rx_rcv_data_start,
   output logic [7:0]             out_data,
   output logic                   out_sof,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   sym_err,
   output logic [cnt_width_c-1:0] sym_err_cnt,
   output logic [cnt_width_c-1:0] ovf_cnt
);

   localparam int AW = $clog2(fifo_depth_c);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(carriers_c) + 1;
   localparam logic [CW-1:0] LAST_C = CW'(carriers_c);

   typedef enum logic {IDLE, COLLECT} state_t;

   // Saturating increment for the status counters; they stick at all-ones.
   function automatic logic [cnt_width_c-1:0] sat_inc(input logic [cnt_width_c-1:0] v);
      return (&v) ? v : v + cnt_width_c'(1);
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            pend_q, pend_d;
   logic            err_q, err_d;
   logic            wr_en;
   logic [8:0]      wr_word;

   logic [8:0]      mem_q [fifo_depth_c];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [cnt_width_c-1:0] sym_err_cnt_q, ovf_cnt_q;

   logic            clear;
   logic            full, empty, rd_en, wr_ok, ovf;
   logic [8:0]      head;

   assign clear = sys_rst | sys_init;

   // Packing FSM: symbol alignment, dibit shifting, byte completion and malformed-symbol detection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pend_d  = pend_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_word = {pend_q, shift_q[5:0], rx_rcv_data};
      if (rx_rcv_data_valid) begin
         if (rx_rcv_data_start) begin
            // A start inside COLLECT can only be early, since completion always returns to IDLE.
            err_d   = (state_q == COLLECT);
            state_d = COLLECT;
            cnt_d   = CW'(1);
            shift_d = {6'b000000, rx_rcv_data};
            pend_d  = 1'b1;
         end else if (state_q == COLLECT) begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = {shift_q[5:0], rx_rcv_data};
            if (cnt_d[1:0] == 2'b00) begin
               wr_en  = 1'b1;
               pend_d = 1'b0;
            end
            if (cnt_d == LAST_C) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Packing datapath registers; a clear drops any partial byte.
   always_ff @(posedge sys_clk) begin
      if (clear) begin
         cnt_q   <= '0;
         shift_q <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   // FIFO status: extra pointer MSB distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en = !empty && out_ready;
   assign wr_ok = wr_en && (!full || rd_en);
   assign ovf   = wr_en && full && !rd_en;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // FIFO storage; contents need no clear because the pointers define validity.
   always_ff @(posedge sys_clk) begin
      if (wr_ok && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
   end

   // FIFO pointers; a clear flushes everything buffered.
   always_ff @(posedge sys_clk) begin
      if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Status counters survive a soft clear, only a hard reset zeroes them.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sym_err_cnt_q <= '0;
         ovf_cnt_q     <= '0;
      end else if (!sys_init) begin
         if (err_d) sym_err_cnt_q <= sat_inc(sym_err_cnt_q);
         if (ovf)   ovf_cnt_q     <= sat_inc(ovf_cnt_q);
      end
   end

   assign out_valid   = !empty;
   assign out_data    = empty ? 8'h00 : head[7:0];
   assign out_sof     = !empty && head[8];
   assign sym_err     = err_q;
   assign sym_err_cnt = sym_err_cnt_q;
   assign ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Directed bench for ofdm_rx_byte_packer: nominal packing, malformed symbols,
// overflow, same-cycle read/write at full, backpressure with gaps, soft clear.
module tb_ofdm_rx_byte_packer;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        sys_init = 1'b0;
   logic [1:0]  rx_rcv_data = 2'b00;
   logic        rx_rcv_data_valid = 1'b0;
   logic        rx_rcv_data_start = 1'b0;
   logic [7:0]  out_data;
   logic        out_sof;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        sym_err;
   logic [15:0] sym_err_cnt;
   logic [15:0] ovf_cnt;

   int          errs = 0;
   int          checks = 0;
   logic [8:0]  got_q [$];
   int          err_pulses = 0;
   int          stall_bad = 0;
   logic        prev_stall = 1'b0;
   logic [8:0]  prev_word = '0;
   bit          tog_en = 1'b0;
   bit          gap_en = 1'b0;

   ofdm_rx_byte_packer #(
      .carriers_c   (64),
      .fifo_depth_c (32),
      .cnt_width_c  (16)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_rst           (sys_rst),
      .sys_init          (sys_init),
      .rx_rcv_data       (rx_rcv_data),
      .rx_rcv_data_valid (rx_rcv_data_valid),
      .rx_rcv_data_start (rx_rcv_data_start),
      .out_data          (out_data),
      .out_sof           (out_sof),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .sym_err           (sym_err),
      .sym_err_cnt       (sym_err_cnt),
      .ovf_cnt           (ovf_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Consumer side: capture transfers, count error pulses, watch head stability while stalled.
   always @(negedge sys_clk) begin
      if (prev_stall && !(out_valid && ({out_sof, out_data} == prev_word)))
         stall_bad <= stall_bad + 1;
      prev_stall <= out_valid && !out_ready && !sys_rst && !sys_init;
      prev_word  <= {out_sof, out_data};
      if (out_valid && out_ready) got_q.push_back({out_sof, out_data});
      if (sym_err) err_pulses <= err_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] d, input logic s);
      @(posedge sys_clk);
      #1;
      rx_rcv_data_valid = v;
      rx_rcv_data       = d;
      rx_rcv_data_start = s;
      if (tog_en) out_ready = ~out_ready;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'b00, 1'b0);
   endtask

   task automatic send_dibit(input logic [1:0] d, input logic s);
      if (gap_en) repeat ($urandom_range(0, 2)) step(1'b0, 2'b00, 1'b0);
      step(1'b1, d, s);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic s);
      send_dibit(b[7:6], s);
      send_dibit(b[5:4], 1'b0);
      send_dibit(b[3:2], 1'b0);
      send_dibit(b[1:0], 1'b0);
   endtask

   // One full symbol: 16 bytes counting up from base.
   task automatic send_sym(input logic [7:0] base);
      for (int i = 0; i < 16; i++) send_byte(base + 8'(i), i == 0);
   endtask

   task automatic soft_clear();
      sys_init = 1'b1;
      step(1'b0, 2'b00, 1'b0);
      sys_init = 1'b0;
   endtask

   task automatic wait_bytes(input string tag, input int base, input int n);
      int cyc = 0;
      while (got_q.size() < base + n && cyc < 2000) begin
         step(1'b0, 2'b00, 1'b0);
         cyc++;
      end
      idle(5);
      chk(tag, got_q.size() - base, n);
   endtask

   task automatic chk_sym(input string tag, input int base, input logic [7:0] first);
      logic [8:0] w;
      for (int i = 0; i < 16; i++) begin
         w = (base + i < got_q.size()) ? got_q[base + i] : 9'h1FF;
         chk(tag, w, {i == 0, first + 8'(i)});
      end
   endtask

   initial begin
      int base;
      int e0;
      int s0;

      // Reset state
      idle(3);
      sys_rst = 1'b0;
      idle(1);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_sof", out_sof, 0);
      chk("rst sym_err", sym_err, 0);
      chk("rst sym_err_cnt", sym_err_cnt, 0);
      chk("rst ovf_cnt", ovf_cnt, 0);

      // Nominal symbol: dibits 3,0,1,2 -> 0xC6
      out_ready = 1'b1;
      base = got_q.size();
      for (int i = 0; i < 16; i++) send_byte(8'hC6, i == 0);
      wait_bytes("nom count", base, 16);
      for (int i = 0; i < 16; i++) chk("nom byte", got_q[base + i], {i == 0, 8'hC6});
      chk("nom sym_err_cnt", sym_err_cnt, 0);

      // Malformed: 10 dibits of 1 then a restart with a full symbol
      base = got_q.size();
      e0 = err_pulses;
      send_dibit(2'd1, 1'b1);
      for (int i = 0; i < 9; i++) send_dibit(2'd1, 1'b0);
      send_sym(8'h10);
      wait_bytes("mal count", base, 18);
      chk("mal byte0", got_q[base], {1'b1, 8'h55});
      chk("mal byte1", got_q[base + 1], {1'b0, 8'h55});
      chk_sym("mal sym", base + 2, 8'h10);
      chk("mal pulses", err_pulses - e0, 1);
      chk("mal sym_err_cnt", sym_err_cnt, 1);

      // Overflow: 3 symbols into a 32-deep FIFO with no reads
      out_ready = 1'b0;
      base = got_q.size();
      send_sym(8'h30);
      send_sym(8'h40);
      send_sym(8'h50);
      idle(3);
      chk("ovf ovf_cnt", ovf_cnt, 16);
      chk("ovf out_valid", out_valid, 1);
      chk("ovf head data", out_data, 8'h30);
      chk("ovf head sof", out_sof, 1);
      chk("ovf no reads", got_q.size() - base, 0);
      out_ready = 1'b1;
      wait_bytes("ovf drain count", base, 32);
      chk_sym("ovf sym0", base, 8'h30);
      chk_sym("ovf sym1", base + 16, 8'h40);
      chk("ovf sym_err_cnt", sym_err_cnt, 1);

      // Same-cycle write and read while full
      out_ready = 1'b0;
      send_sym(8'h80);
      send_sym(8'h90);
      idle(2);
      chk("rw full ovf pre", ovf_cnt, 16);
      base = got_q.size();
      send_dibit(2'd2, 1'b1);
      send_dibit(2'd2, 1'b0);
      send_dibit(2'd0, 1'b0);
      send_dibit(2'd0, 1'b0);
      out_ready = 1'b1;
      step(1'b0, 2'b00, 1'b0);
      out_ready = 1'b0;
      idle(3);
      chk("rw one read", got_q.size() - base, 1);
      chk("rw ovf_cnt", ovf_cnt, 16);
      chk("rw head", out_data, 8'h81);
      out_ready = 1'b1;
      wait_bytes("rw drain count", base, 33);
      chk_sym("rw sym0", base, 8'h80);
      chk_sym("rw sym1", base + 16, 8'h90);
      chk("rw last", got_q[base + 32], {1'b1, 8'hA0});
      soft_clear();
      idle(2);

      // Backpressure toggling every cycle and random valid gaps
      base = got_q.size();
      s0 = stall_bad;
      out_ready = 1'b1;
      tog_en = 1'b1;
      gap_en = 1'b1;
      send_sym(8'h30);
      wait_bytes("bp count", base, 16);
      tog_en = 1'b0;
      gap_en = 1'b0;
      out_ready = 1'b1;
      chk_sym("bp sym", base, 8'h30);
      chk("bp stall stable", stall_bad - s0, 0);

      // Pre-sync dibits are ignored, then a full symbol
      base = got_q.size();
      for (int i = 0; i < 20; i++) send_dibit(2'(i), 1'b0);
      idle(4);
      chk("presync none", got_q.size() - base, 0);
      send_sym(8'h60);
      wait_bytes("presync count", base, 16);
      chk_sym("presync sym", base, 8'h60);

      // Soft clear mid-symbol with bytes buffered
      out_ready = 1'b0;
      base = got_q.size();
      for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), i == 0);
      send_dibit(2'd1, 1'b0);
      send_dibit(2'd1, 1'b0);
      idle(2);
      chk("init pre valid", out_valid, 1);
      chk("init pre head", out_data, 8'h70);
      soft_clear();
      chk("init out_valid", out_valid, 0);
      chk("init out_data", out_data, 0);
      chk("init out_sof", out_sof, 0);
      chk("init sym_err_cnt", sym_err_cnt, 1);
      chk("init ovf_cnt", ovf_cnt, 16);
      out_ready = 1'b1;
      idle(3);
      chk("init flushed", got_q.size() - base, 0);
      send_sym(8'h50);
      wait_bytes("init next count", base, 16);
      chk_sym("init next sym", base, 8'h50);
      chk("init no err", sym_err_cnt, 1);

      // Hard reset clears the counters
      sys_rst = 1'b1;
      step(1'b0, 2'b00, 1'b0);
      sys_rst = 1'b0;
      chk("hrst sym_err_cnt", sym_err_cnt, 0);
      chk("hrst ovf_cnt", ovf_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ofdm_rx_byte_packer.md
Name: ofdm_rx_byte_packer

Overview:
- Downstream consumer of the OFDM RX path's demodulated output: `rx_rcv_data`, `rx_rcv_data_valid` and `rx_rcv_data_start`.
- Packs QPSK dibits into bytes, aligned to each OFDM symbol start, and buffers them in a small FIFO.
- Delivers bytes over a valid/ready stream with a start-of-symbol marker.
- Flags malformed symbols and FIFO overflow drops for the system controller.

Parameters:
- `carriers_c`, 64, dibits per OFDM symbol. Must be a multiple of 4.
- `fifo_depth_c`, 32, output FIFO depth in bytes. Must be a power of 2, ≥ 4.
- `cnt_width_c`, 16, width of the saturating error counters.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `sys_init` in 1: synchronous soft clear. Same effect as `sys_rst` except the counters keep their values.
- `rx_rcv_data` in 2: demodulated dibit. Bit 1 is the earlier bit on the air.
- `rx_rcv_data_valid` in 1: dibit qualifier.
- `rx_rcv_data_start` in 1: high together with the valid first dibit of a symbol.
- `out_data` out 8: packed byte.
- `out_sof` out 1: byte is the first byte of a symbol.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head byte.
- `sym_err` out 1: one-cycle pulse when a symbol is detected as malformed.
- `sym_err_cnt` out `cnt_width_c`: saturating count of malformed symbols.
- `ovf_cnt` out `cnt_width_c`: saturating count of bytes dropped because the FIFO was full.

Behaviour:
- Reset (`sys_rst`=1): state=IDLE, dibit counter=0, shift register=0, FIFO empty, `out_valid`=0, `out_data`=0, `out_sof`=0, `sym_err`=0, both counters=0.
- `sys_init`=1: identical to reset but leaves `sym_err_cnt` and `ovf_cnt` unchanged.
- If reset or `sys_init` asserts mid-symbol, the partial byte and all FIFO contents are discarded.
- IDLE state:
  - Dibits with valid=1 and start=0 are ignored. No error is raised.
  - valid=1 with start=1: load the dibit into the shift register, set dibit counter=1, latch the `pending_sof` flag, go to COLLECT.
- COLLECT state:
  - Each valid dibit shifts in MSB-first: `byte = {byte[5:0], dibit}`. The first dibit lands in bits 7:6.
  - Dibit counter increments on every accepted dibit.
  - Every 4th dibit completes a byte. The byte is written to the FIFO with `sof=pending_sof`, then `pending_sof` is cleared.
  - When the counter reaches `carriers_c`: the final byte is written in that same cycle, return to IDLE.
- Malformed symbol: `start`=1 arrives in COLLECT before `carriers_c` dibits have been accepted.
  - `sym_err` pulses for 1 cycle and `sym_err_cnt` increments (saturating).
  - Bytes already written stay in the FIFO. The partial byte is dropped.
  - The new dibit is taken as the first dibit of a new symbol (same action as IDLE with start), staying in COLLECT.
- Completion and new start in the same cycle:
  - When the `carriers_c`-th dibit arrives, the counter is at `carriers_c`−1, so start cannot coincide legally with it.
  - start=1 on the dibit after completion is processed in IDLE and is legal.
- Gaps: valid=0 cycles are allowed anywhere. State is held.
- FIFO write latency: the byte is visible at `out_valid`/`out_data` on the cycle after its 4th dibit, when the FIFO was empty.
  - The outputs are registered FIFO head, first-word-fall-through.
- Output handshake:
  - A transfer occurs when `out_valid`=1 and `out_ready`=1 in the same cycle.
  - `out_data`/`out_sof` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` drops only after the last byte is transferred.
- Full FIFO:
  - A write attempted while full with no same-cycle read is discarded, and `ovf_cnt` increments (saturating).
  - A write and a read in the same cycle when full both succeed (occupancy unchanged).
- Empty FIFO: a read is impossible since `out_valid`=0. A write and a read in the same cycle when occupancy=1 keep `out_valid`=1.
- Counters saturate at 2^`cnt_width_c`−1 and never wrap.
- Read and write pointers are log2(`fifo_depth_c`)+1 bits wide, wrap modulo 2·`fifo_depth_c`, and full/empty are decided by comparing the MSBs.

Test Plan:
- Nominal symbol, no backpressure:
  - Stimulus: start with dibits 3,0,1,2 repeating, 64 dibits total, `out_ready`=1.
  - Required: 16 bytes of 0xC6, the first with `out_sof`=1; `sym_err_cnt`=0.
- Malformed symbol:
  - Stimulus: start, 10 dibits of value 1, then start again followed by a full 64-dibit symbol.
  - Required: 2 bytes of 0x55 (`sof` on the first), then 16 bytes with `sof` on the 3rd output byte; `sym_err` pulses once; `sym_err_cnt`=1.
- Overflow:
  - Stimulus: `out_ready`=0, 3 full symbols (48 bytes) into a depth-32 FIFO.
  - Required: 32 bytes held, `ovf_cnt`=16; after releasing `out_ready`=1, exactly 32 bytes drain in order.
- Backpressure and gaps:
  - Stimulus: random valid gaps and `out_ready` toggling every cycle over 1 symbol.
  - Required: byte stream identical to the no-stall run; `out_data` never changes while stalled.
- Pre-sync dibits and soft clear:
  - Stimulus: 20 valid dibits with start=0 in IDLE, then a full symbol.
  - Required: exactly 16 output bytes.
  - Stimulus (continued): assert `sys_init` mid-symbol, then send a full symbol.
  - Required: FIFO flushes, counters are unchanged, and the next symbol output is correct.
- Same-cycle read/write at full: fill to 32, then write and read together → occupancy stays 32 and `ovf_cnt` is unchanged.
